// File: rtl/xalu_seq.sv
// xalu_seq: sequential ALU with single-cycle logic/arithmetic, multi-cycle SHR and shift-add MUL
// Ports: clk/rst (sync, active-high); start/f/a/b/use_acc/ci/com request an operation;
// y/co/zero/neg_zero/equ are the registered result and flags; busy/done report progress.
module xalu_seq #(
    parameter int WIDTH = 8,
    parameter int SAW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       f,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             use_acc,
    input  logic             ci,
    input  logic             com,
    output logic [WIDTH-1:0] y,
    output logic             co,
    output logic             zero,
    output logic             neg_zero,
    output logic             equ,
    output logic             busy,
    output logic             done
);
    // One counter serves both the shift amount and the multiplier bit count.
    localparam int CW = (SAW > $clog2(WIDTH + 1)) ? SAW : $clog2(WIDTH + 1);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL} state_t;
    state_t r_state, w_next;
    logic [WIDTH-1:0]   r_y, r_sh, r_mp;
    logic [2*WIDTH-1:0] r_prod, r_mc;
    logic [CW-1:0]      r_cnt;
    logic               r_co, r_zero, r_nz, r_equ, r_done, r_ci, r_com, r_eq;
    logic               w_acc, w_single, w_commit, w_sco, w_co, w_eq, w_com;
    logic [WIDTH-1:0]   w_opa, w_sres, w_res, w_sh_next, w_y;
    logic [WIDTH:0]     w_add, w_sub;
    logic [2*WIDTH-1:0] w_prod_next;
    logic [SAW-1:0]     w_n;

    always_comb begin
        w_opa       = use_acc ? r_y : a;
        w_n         = b[SAW-1:0];
        w_acc       = (r_state == S_IDLE) && start;
        w_add       = {1'b0, w_opa} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
        w_sub       = {1'b0, w_opa} + {1'b0, ~b} + {{WIDTH{1'b0}}, ci};
        // SHR by zero completes immediately as a pass of operand A.
        w_single    = (f <= 3'd5) || ((f == 3'd6) && (w_n == '0));
        w_sco       = (f == 3'd0) ? w_add[WIDTH] : (f == 3'd4) ? w_sub[WIDTH] : 1'b0;
        w_sres      = (f == 3'd0) ? w_add[WIDTH-1:0] :
                      (f == 3'd1) ? (w_opa & b) :
                      (f == 3'd2) ? (w_opa | b) :
                      (f == 3'd3) ? (w_opa ^ b) :
                      (f == 3'd4) ? w_sub[WIDTH-1:0] :
                      (f == 3'd5) ? b : w_opa;
        w_sh_next   = {r_ci, r_sh[WIDTH-1:1]};
        w_prod_next = r_prod + (r_mp[0] ? r_mc : '0);
        // Multi-cycle ops finish on the cycle their counter reaches one.
        w_commit    = (w_acc && w_single) || ((r_state != S_IDLE) && (r_cnt == CW'(1)));
        w_res       = (r_state == S_SHIFT) ? w_sh_next :
                      (r_state == S_MUL)   ? w_prod_next[WIDTH-1:0] : w_sres;
        w_co        = (r_state == S_SHIFT) ? r_sh[0] :
                      (r_state == S_MUL)   ? |w_prod_next[2*WIDTH-1:WIDTH] : w_sco;
        w_eq        = (r_state == S_IDLE) ? (w_opa == b) : r_eq;
        w_com       = (r_state == S_IDLE) ? com : r_com;
        w_y         = w_res ^ {WIDTH{w_com}};
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = !w_acc ? S_IDLE : (f == 3'd7) ? S_MUL : w_single ? S_IDLE : S_SHIFT;
            S_SHIFT: w_next = (r_cnt == CW'(1)) ? S_IDLE : S_SHIFT;
            S_MUL:   w_next = (r_cnt == CW'(1)) ? S_IDLE : S_MUL;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state != S_IDLE);
        done     = r_done;
        y        = r_y;
        co       = r_co;
        zero     = r_zero;
        neg_zero = r_nz;
        equ      = r_equ;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y    <= '0;
            r_co   <= 1'b0;
            r_zero <= 1'b1;
            r_nz   <= 1'b0;
            r_equ  <= 1'b0;
            r_done <= 1'b0;
            r_ci   <= 1'b0;
            r_com  <= 1'b0;
            r_eq   <= 1'b0;
            r_sh   <= '0;
            r_prod <= '0;
            r_mc   <= '0;
            r_mp   <= '0;
            r_cnt  <= '0;
        end else begin
            r_done <= w_commit;
            if (w_commit) begin
                r_y    <= w_y;
                r_co   <= w_co;
                r_zero <= (w_y == '0);
                r_nz   <= &w_y;
                r_equ  <= w_eq;
            end
            if (w_acc) begin
                r_ci   <= ci;
                r_com  <= com;
                r_eq   <= (w_opa == b);
                r_sh   <= w_opa;
                r_prod <= '0;
                r_mc   <= {{WIDTH{1'b0}}, w_opa};
                r_mp   <= b;
                r_cnt  <= (f == 3'd7) ? CW'(WIDTH) : CW'(w_n);
            end else if (r_state == S_SHIFT) begin
                r_sh   <= w_sh_next;
                r_cnt  <= r_cnt - CW'(1);
            end else if (r_state == S_MUL) begin
                r_prod <= w_prod_next;
                r_mc   <= r_mc << 1;
                r_mp   <= r_mp >> 1;
                r_cnt  <= r_cnt - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_xalu_seq.sv
// tb_xalu_seq: directed vector bench for xalu_seq at WIDTH=8
module tb_xalu_seq;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, use_acc = 1'b0, ci = 1'b0, com = 1'b0;
    logic [2:0] f = 3'd0;
    logic [7:0] a = 8'h00, b = 8'h00;
    logic [7:0] y;
    logic       co, zero, neg_zero, equ, busy, done;
    int         errors = 0, checks = 0;

    xalu_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .f(f), .a(a), .b(b), .use_acc(use_acc),
        .ci(ci), .com(com), .y(y), .co(co), .zero(zero), .neg_zero(neg_zero),
        .equ(equ), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] f;
        logic [7:0] a;
        logic [7:0] b;
        logic       ua;
        logic       ci;
        logic       com;
        logic [7:0] ey;
        logic       eco;
        logic       ez;
        logic       enz;
        logic       eeq;
        logic [4:0] lat;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input int idx);
        int  got;
        logic busy_ok;
        f = v.f; a = v.a; b = v.b; use_acc = v.ua; ci = v.ci; com = v.com; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        got = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (busy !== (k < int'(v.lat))) busy_ok = 1'b0;
            if (done === 1'b1) begin
                got = k;
                break;
            end
        end
        chk($sformatf("v%0d_latency", idx), got, {27'd0, v.lat});
        chk($sformatf("v%0d_busy", idx), {31'd0, busy_ok}, 32'd1);
        chk($sformatf("v%0d_y", idx), {24'd0, y}, {24'd0, v.ey});
        chk($sformatf("v%0d_co", idx), {31'd0, co}, {31'd0, v.eco});
        chk($sformatf("v%0d_zero", idx), {31'd0, zero}, {31'd0, v.ez});
        chk($sformatf("v%0d_neg_zero", idx), {31'd0, neg_zero}, {31'd0, v.enz});
        chk($sformatf("v%0d_equ", idx), {31'd0, equ}, {31'd0, v.eeq});
    endtask

    initial begin
        int got;
        //                f     a      b      ua    ci    com   y      co    z     nz    eq    lat
        vecs[0]  = '{3'd0, 8'hF0, 8'h20, 1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1};
        vecs[1]  = '{3'd7, 8'h14, 8'h14, 1'b0, 1'b0, 1'b0, 8'h90, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9};
        vecs[2]  = '{3'd7, 8'h0D, 8'h0B, 1'b0, 1'b0, 1'b0, 8'h8F, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9};
        vecs[3]  = '{3'd6, 8'h81, 8'h03, 1'b0, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4};
        vecs[4]  = '{3'd6, 8'h81, 8'h00, 1'b0, 1'b1, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1};
        vecs[5]  = '{3'd3, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1};
        vecs[6]  = '{3'd0, 8'h33, 8'h01, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1};
        vecs[7]  = '{3'd1, 8'hCC, 8'hAA, 1'b0, 1'b0, 1'b0, 8'h88, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1};
        vecs[8]  = '{3'd2, 8'hCC, 8'hAA, 1'b0, 1'b1, 1'b0, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1};
        vecs[9]  = '{3'd4, 8'h10, 8'h20, 1'b0, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1};
        vecs[10] = '{3'd4, 8'h20, 8'h10, 1'b0, 1'b1, 1'b0, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1};
        vecs[11] = '{3'd5, 8'h7E, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1};
        vecs[12] = '{3'd6, 8'hC0, 8'h07, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8};
        vecs[13] = '{3'd7, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9};
        vecs[14] = '{3'd4, 8'h00, 8'hFE, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 5'd1};
        vecs[15] = '{3'd6, 8'h55, 8'h08, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_y", {24'd0, y}, 32'h0);
        chk("reset_co", {31'd0, co}, 32'd0);
        chk("reset_zero", {31'd0, zero}, 32'd1);
        chk("reset_neg_zero", {31'd0, neg_zero}, 32'd0);
        chk("reset_equ", {31'd0, equ}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);

        // Each call issues start in the done cycle of the previous one (back-to-back).
        for (int i = 0; i < 16; i++) run_op(vecs[i], i);

        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);

        f = 3'd7; a = 8'h14; b = 8'h14; use_acc = 1'b0; ci = 1'b0; com = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        got = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 3) begin
                start = 1'b1; f = 3'd0; a = 8'h01; b = 8'h01;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                got = k;
                break;
            end
        end
        chk("ignore_latency", got, 32'd9);
        chk("ignore_y", {24'd0, y}, 32'h90);
        chk("ignore_co", {31'd0, co}, 32'd1);
        @(negedge clk);
        chk("ignore_no_extra_done", {31'd0, done}, 32'd0);
        chk("ignore_y_hold", {24'd0, y}, 32'h90);

        f = 3'd7; a = 8'h0D; b = 8'h0B; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        chk("abort_y_hold", {24'd0, y}, 32'h90);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_y", {24'd0, y}, 32'h0);
        chk("abort_zero", {31'd0, zero}, 32'd1);
        chk("abort_co", {31'd0, co}, 32'd0);
        got = 0;
        for (int k = 0; k < 12; k++) begin
            if (done === 1'b1) got++;
            @(negedge clk);
        end
        chk("abort_no_done", got, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/xalu_seq.md
XALU_SEQ -- requirements
Module: xalu_seq

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal values 4..32.
REQ-002 Parameter: SAW, default $clog2(WIDTH), width of the shift-amount field taken from b.
REQ-003 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: start  input  1  request an operation; sampled only in IDLE.
REQ-006 Port: f  input  3  function code: 0 ADD, 1 AND, 2 OR, 3 XOR, 4 SUB, 5 PASSB, 6 SHR, 7 MUL.
REQ-007 Port: a, b  input  WIDTH each  operands.
REQ-008 Port: use_acc  input  1  when 1, operand A is the current y register instead of a.
REQ-009 Port: ci  input  1  carry-in for ADD and SUB; shift-in bit for SHR.
REQ-010 Port: com  input  1  ones-complement the result before it is registered.
REQ-011 Port: y  output  WIDTH  result/accumulator register.
REQ-012 Port: co  output  1  carry flag; zero, neg_zero, equ  output  1 each  status flags.
REQ-013 Port: busy  output  1  high while a multi-cycle operation runs; done  output  1  one-cycle completion pulse.

Function
REQ-014 States: IDLE, SHIFT, MUL; busy = (state != IDLE).
REQ-015 Operands latch at the start-accept edge (start=1 in IDLE); A = use_acc ? y : a; f, b, ci, com latch at the same edge.
REQ-016 Single-cycle ops (f=0..5): result registered at the accept edge; done=1 in the next cycle; state stays IDLE.
REQ-017 ADD: {co,r} = A + b + ci. SUB: {co,r} = A + ~b + ci, so co=1 means no borrow. AND/OR/XOR/PASSB: bitwise, co=0.
REQ-018 SHR: amount n = b[SAW-1:0]; n=0 behaves as single-cycle PASSA with co=0; otherwise the block enters SHIFT for n cycles.
REQ-019 Each SHIFT cycle: r <= {ci_latched, r[WIDTH-1:1]}, co <= r[0], n decrements; at n=1 the state returns to IDLE and done pulses in the following cycle.
REQ-020 MUL: unsigned shift-add, one multiplier bit per cycle, WIDTH cycles in MUL; y = product[WIDTH-1:0]; co = |product[2*WIDTH-1:WIDTH].
REQ-021 Latency from the accept cycle c0 to done: single-cycle ops c1; SHR c(n+1); MUL c(WIDTH+1); busy is high in c1..cn or c1..cWIDTH respectively.
REQ-022 y, co, and flags update only on completion; they hold their previous values while busy and until the next completion.
REQ-023 com: y <= r ^ {WIDTH{com_latched}}; co is not inverted.
REQ-024 Flags registered with y: zero = (y == 0); neg_zero = (y == all ones); equ = (A == b) evaluated on the latched operands.
REQ-025 start while busy is ignored: no latch, no queueing, and no effect on the operation in progress.
REQ-026 start in the done cycle is accepted normally, which allows back-to-back operations.
REQ-027 Undefined widths do not occur; all arithmetic wraps modulo 2^WIDTH, with overflow reported only via co.

Reset
REQ-028 At an rst=1 edge: state=IDLE, y=0, co=0, zero=1, neg_zero=0, equ=0, busy=0, done=0, and internal counters and product are cleared.
REQ-029 rst takes priority over start and aborts SHIFT/MUL mid-operation; no done pulse is issued for the aborted operation.

Verification (WIDTH=8)
REQ-030 ADD a=0xF0 b=0x20 ci=1 -> y=0x11, co=1, done in c1, busy never high.
REQ-031 MUL a=20 b=20 -> busy c1..c8, done c9, y=0x90, co=1; MUL 13*11 -> y=0x8F, co=0.
REQ-032 SHR a=0x81 b=3 ci=1 -> done c4, y=0xF0, co=0; b=0 -> done c1, y=0x81.
REQ-033 XOR a=b=0x5A com=1 -> y=0xFF, neg_zero=1, zero=0, equ=1; then ADD use_acc=1 b=0x01 ci=0 -> y=0x00, co=1, zero=1.
REQ-034 start pulsed at c3 during MUL -> ignored, MUL result unchanged at c9; rst at c4 of a MUL -> next cycle IDLE, y=0, no done.
